// File: rtl/axi_slv_pkg.sv
// Shared definitions for the AXI burst slave memory.
// Holds the two response codes driven on BRESP/RRESP and the state
// enumerations for the independent write and read FSMs.
package axi_slv_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } wrState_e;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rdState_e;

endpackage

// File: rtl/axi_slv_mem_array.sv
// Byte-enabled register array backing the AXI slave memory.
// The array is cleared asynchronously while reset is low. It has one
// byte-enabled write port and one combinational read port. The caller
// registers the read data, so a read and a write to the same word on the
// same edge return the old contents.
// Ports:
//   clk_i    - clock, rising edge
//   rstN_i   - asynchronous active-low clear of the whole array
//   we_i     - write enable for this edge
//   wIdx_i   - word index written
//   wStrb_i  - one enable bit per byte lane
//   wData_i  - write data
//   rIdx_i   - word index read
//   rData_o  - combinational read data
module axi_slv_mem_array #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int IDX_W  = 6
) (
  input  logic                  clk_i,
  input  logic                  rstN_i,
  input  logic                  we_i,
  input  logic [IDX_W-1:0]      wIdx_i,
  input  logic [DATA_W/8-1:0]   wStrb_i,
  input  logic [DATA_W-1:0]     wData_i,
  input  logic [IDX_W-1:0]      rIdx_i,
  output logic [DATA_W-1:0]     rData_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Storage: wiped on reset, otherwise only the strobed byte lanes of the
  // addressed word are updated.
  always_ff @(posedge clk_i or negedge rstN_i) begin
    if (!rstN_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      for (int b = 0; b < DATA_W/8; b++) begin
        if (wStrb_i[b]) begin
          mem_q[wIdx_i][b*8 +: 8] <= wData_i[b*8 +: 8];
        end
      end
    end
  end

  assign rData_o = mem_q[rIdx_i];

endmodule

// File: rtl/axi_slave_burst_mem.sv
// AXI slave memory with incrementing write and read bursts.
// Independent write (AW/W/B) and read (AR/R) FSMs share one byte-enabled
// array. Addresses are word indices; a burst is LEN+1 beats.
// Optional feature: define AXI_SLV_ADDR_CHK_EN to flag any beat whose full
// address is >= DEPTH (writes suppressed with SLVERR, reads return zero with
// SLVERR). Without it the index simply wraps; DEPTH is expected to be a
// power of two so that wrapping is modulo DEPTH.
// Ports:
//   S_ACLK, S_ARRESET_N                      - clock, async active-low reset
//   M_AWVALID/M_AWADDR/M_AWLEN/S_AWREADY      - write address channel
//   M_WVALID/M_WDATA/M_WSTRB/M_WLAST/S_WREADY - write data channel
//   S_BVALID/S_BRESP/M_BREADY                 - write response channel
//   M_ARVALID/M_ARADDR/M_BLEN/S_ARREADY       - read address channel
//   S_RVALID/S_RDATA/S_RRESP/S_RLAST/M_RREADY - read data channel
module axi_slave_burst_mem
  import axi_slv_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 64,
  parameter int LEN_W  = 4
) (
  input  logic                S_ACLK,
  input  logic                S_ARRESET_N,
  input  logic                M_AWVALID,
  input  logic [ADDR_W-1:0]   M_AWADDR,
  input  logic [LEN_W-1:0]    M_AWLEN,
  output logic                S_AWREADY,
  input  logic                M_WVALID,
  input  logic [DATA_W-1:0]   M_WDATA,
  input  logic [DATA_W/8-1:0] M_WSTRB,
  input  logic                M_WLAST,
  output logic                S_WREADY,
  output logic                S_BVALID,
  output logic [1:0]          S_BRESP,
  input  logic                M_BREADY,
  input  logic                M_ARVALID,
  input  logic [ADDR_W-1:0]   M_ARADDR,
  input  logic [LEN_W-1:0]    M_BLEN,
  output logic                S_ARREADY,
  output logic                S_RVALID,
  output logic [DATA_W-1:0]   S_RDATA,
  output logic [1:0]          S_RRESP,
  output logic                S_RLAST,
  input  logic                M_RREADY
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Write path state
  wrState_e            wState_q, wState_d;
  logic [ADDR_W-1:0]   wAddr_q, wAddr_d;
  logic [LEN_W-1:0]    wLen_q, wLen_d;
  logic [LEN_W-1:0]    wCnt_q, wCnt_d;
  logic                wErr_q, wErr_d;
  logic                awReady_q, wReady_q, bValid_q;
  logic                wLastBeat, wOor, memWe;

  // Read path state
  rdState_e            rState_q, rState_d;
  logic [ADDR_W-1:0]   rAddr_q, rAddr_d;
  logic [LEN_W-1:0]    rLen_q, rLen_d;
  logic [LEN_W-1:0]    rCnt_q, rCnt_d;
  logic [DATA_W-1:0]   rData_q, rData_d;
  logic [1:0]          rResp_q, rResp_d;
  logic                arReady_q, rValid_q;
  logic [ADDR_W-1:0]   rAddrNext, rdAddr;
  logic                rdOor;
  logic [DATA_W-1:0]   memRdata, loadData;
  logic [1:0]          loadResp;

  axi_slv_mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) uMem (
    .clk_i   (S_ACLK),
    .rstN_i  (S_ARRESET_N),
    .we_i    (memWe),
    .wIdx_i  (wAddr_q[IDX_W-1:0]),
    .wStrb_i (M_WSTRB),
    .wData_i (M_WDATA),
    .rIdx_i  (rdAddr[IDX_W-1:0]),
    .rData_o (memRdata)
  );

  assign wLastBeat = (wCnt_q == wLen_q);
  assign rAddrNext = rAddr_q + 1'b1;
  // The read port looks at the incoming AR address while idle, and at the
  // following word while a burst is in flight, so the next beat is ready
  // the edge after each handshake.
  assign rdAddr    = (rState_q == R_IDLE) ? M_ARADDR : rAddrNext;

`ifdef AXI_SLV_ADDR_CHK_EN
  assign wOor  = (wAddr_q >= ADDR_W'(DEPTH));
  assign rdOor = (rdAddr >= ADDR_W'(DEPTH));
`else
  logic unusedRdAddrHigh;
  assign wOor  = 1'b0;
  assign rdOor = 1'b0;
  assign unusedRdAddrHigh = ^rdAddr;
`endif

  assign loadData = rdOor ? '0 : memRdata;
  assign loadResp = rdOor ? RESP_SLVERR : RESP_OKAY;

  // Write FSM next state: accept an address, take LEN+1 data beats (wait
  // cycles allowed), then hold the response until the master takes it.
  // A WLAST that disagrees with the beat count only marks the burst as
  // failed; the data is still stored.
  always_comb begin
    wState_d = wState_q;
    wAddr_d  = wAddr_q;
    wLen_d   = wLen_q;
    wCnt_d   = wCnt_q;
    wErr_d   = wErr_q;
    memWe    = 1'b0;
    case (wState_q)
      W_IDLE: begin
        if (awReady_q && M_AWVALID) begin
          wAddr_d  = M_AWADDR;
          wLen_d   = M_AWLEN;
          wCnt_d   = '0;
          wErr_d   = 1'b0;
          wState_d = W_DATA;
        end
      end
      W_DATA: begin
        if (wReady_q && M_WVALID) begin
          memWe   = !wOor;
          wAddr_d = wAddr_q + 1'b1;
          wCnt_d  = wCnt_q + 1'b1;
          if ((M_WLAST != wLastBeat) || wOor) begin
            wErr_d = 1'b1;
          end
          if (wLastBeat) begin
            wState_d = W_RESP;
          end
        end
      end
      W_RESP: begin
        if (bValid_q && M_BREADY) begin
          wState_d = W_IDLE;
        end
      end
      default: wState_d = W_IDLE;
    endcase
  end

  // Write FSM registers. The channel handshake flags are registered copies
  // of the next state, so they are all low in reset and AWREADY rises on
  // the first edge after release.
  always_ff @(posedge S_ACLK or negedge S_ARRESET_N) begin
    if (!S_ARRESET_N) begin
      wState_q  <= W_IDLE;
      wAddr_q   <= '0;
      wLen_q    <= '0;
      wCnt_q    <= '0;
      wErr_q    <= 1'b0;
      awReady_q <= 1'b0;
      wReady_q  <= 1'b0;
      bValid_q  <= 1'b0;
    end else begin
      wState_q  <= wState_d;
      wAddr_q   <= wAddr_d;
      wLen_q    <= wLen_d;
      wCnt_q    <= wCnt_d;
      wErr_q    <= wErr_d;
      awReady_q <= (wState_d == W_IDLE);
      wReady_q  <= (wState_d == W_DATA);
      bValid_q  <= (wState_d == W_RESP);
    end
  end

  // Read FSM next state: on AR capture the burst and preload beat 0; on
  // each R handshake either finish or preload the following word. Data and
  // response only change on a handshake, so they hold through stalls.
  always_comb begin
    rState_d = rState_q;
    rAddr_d  = rAddr_q;
    rLen_d   = rLen_q;
    rCnt_d   = rCnt_q;
    rData_d  = rData_q;
    rResp_d  = rResp_q;
    case (rState_q)
      R_IDLE: begin
        if (arReady_q && M_ARVALID) begin
          rAddr_d  = M_ARADDR;
          rLen_d   = M_BLEN;
          rCnt_d   = '0;
          rData_d  = loadData;
          rResp_d  = loadResp;
          rState_d = R_DATA;
        end
      end
      R_DATA: begin
        if (rValid_q && M_RREADY) begin
          if (rCnt_q == rLen_q) begin
            rState_d = R_IDLE;
          end else begin
            rAddr_d = rAddrNext;
            rCnt_d  = rCnt_q + 1'b1;
            rData_d = loadData;
            rResp_d = loadResp;
          end
        end
      end
      default: rState_d = R_IDLE;
    endcase
  end

  // Read FSM registers, with ARREADY/RVALID derived from the next state in
  // the same way as the write side.
  always_ff @(posedge S_ACLK or negedge S_ARRESET_N) begin
    if (!S_ARRESET_N) begin
      rState_q  <= R_IDLE;
      rAddr_q   <= '0;
      rLen_q    <= '0;
      rCnt_q    <= '0;
      rData_q   <= '0;
      rResp_q   <= RESP_OKAY;
      arReady_q <= 1'b0;
      rValid_q  <= 1'b0;
    end else begin
      rState_q  <= rState_d;
      rAddr_q   <= rAddr_d;
      rLen_q    <= rLen_d;
      rCnt_q    <= rCnt_d;
      rData_q   <= rData_d;
      rResp_q   <= rResp_d;
      arReady_q <= (rState_d == R_IDLE);
      rValid_q  <= (rState_d == R_DATA);
    end
  end

  assign S_AWREADY = awReady_q;
  assign S_WREADY  = wReady_q;
  assign S_BVALID  = bValid_q;
  assign S_BRESP   = (bValid_q && wErr_q) ? RESP_SLVERR : RESP_OKAY;
  assign S_ARREADY = arReady_q;
  assign S_RVALID  = rValid_q;
  assign S_RDATA   = rData_q;
  assign S_RRESP   = rResp_q;
  assign S_RLAST   = rValid_q && (rCnt_q == rLen_q);

endmodule

// File: tb/tb_axi_slave_burst_mem.sv
// Testbench for axi_slave_burst_mem: directed write/read bursts against a
// word-array model of the memory, with expected R beats and B responses
// queued per transaction and checked every cycle by one compare process.
module tb_axi_slave_burst_mem;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int DEPTH  = 64;
  localparam int LEN_W  = 4;

  logic                S_ACLK;
  logic                S_ARRESET_N;
  logic                M_AWVALID;
  logic [ADDR_W-1:0]   M_AWADDR;
  logic [LEN_W-1:0]    M_AWLEN;
  logic                S_AWREADY;
  logic                M_WVALID;
  logic [DATA_W-1:0]   M_WDATA;
  logic [DATA_W/8-1:0] M_WSTRB;
  logic                M_WLAST;
  logic                S_WREADY;
  logic                S_BVALID;
  logic [1:0]          S_BRESP;
  logic                M_BREADY;
  logic                M_ARVALID;
  logic [ADDR_W-1:0]   M_ARADDR;
  logic [LEN_W-1:0]    M_BLEN;
  logic                S_ARREADY;
  logic                S_RVALID;
  logic [DATA_W-1:0]   S_RDATA;
  logic [1:0]          S_RRESP;
  logic                S_RLAST;
  logic                M_RREADY;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic [1:0]        resp;
    logic              last;
  } rbeat_t;

  int                vectors = 0;
  int                miscompares = 0;
  logic [DATA_W-1:0] model [DEPTH];
  rbeat_t            rq [$];
  logic [1:0]        bq [$];
  logic [DATA_W-1:0] capData [$];
  logic [1:0]        capResp [$];
  logic              capLast [$];
  logic [1:0]        capBresp;

  axi_slave_burst_mem #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .LEN_W  (LEN_W)
  ) dut (
    .S_ACLK      (S_ACLK),
    .S_ARRESET_N (S_ARRESET_N),
    .M_AWVALID   (M_AWVALID),
    .M_AWADDR    (M_AWADDR),
    .M_AWLEN     (M_AWLEN),
    .S_AWREADY   (S_AWREADY),
    .M_WVALID    (M_WVALID),
    .M_WDATA     (M_WDATA),
    .M_WSTRB     (M_WSTRB),
    .M_WLAST     (M_WLAST),
    .S_WREADY    (S_WREADY),
    .S_BVALID    (S_BVALID),
    .S_BRESP     (S_BRESP),
    .M_BREADY    (M_BREADY),
    .M_ARVALID   (M_ARVALID),
    .M_ARADDR    (M_ARADDR),
    .M_BLEN      (M_BLEN),
    .S_ARREADY   (S_ARREADY),
    .S_RVALID    (S_RVALID),
    .S_RDATA     (S_RDATA),
    .S_RRESP     (S_RRESP),
    .S_RLAST     (S_RLAST),
    .M_RREADY    (M_RREADY)
  );

  // Free-running 10-unit clock.
  initial begin
    S_ACLK = 1'b0;
    forever #5 S_ACLK = ~S_ACLK;
  end

  // Hard stop in case something wedges beyond every per-wait bound.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time exceeded, got running expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock step; inputs change 1 unit after the rising edge.
  task automatic applyStimulus();
    @(posedge S_ACLK);
    #1;
  endtask

  // Every negedge: any valid R beat or B response must match the head of
  // the expectation queue; it is retired when the master is ready.
  always @(negedge S_ACLK) begin
    if (S_ARRESET_N) begin
      if (S_RVALID) begin
        if (rq.size() == 0) begin
          checkOutput("rvalid_spurious", S_RVALID, 0);
        end else begin
          checkOutput("rdata", S_RDATA, rq[0].data);
          checkOutput("rresp", S_RRESP, rq[0].resp);
          checkOutput("rlast", S_RLAST, rq[0].last);
          if (M_RREADY) begin
            capData.push_back(S_RDATA);
            capResp.push_back(S_RRESP);
            capLast.push_back(S_RLAST);
            void'(rq.pop_front());
          end
        end
      end
      if (S_BVALID) begin
        if (bq.size() == 0) begin
          checkOutput("bvalid_spurious", S_BVALID, 0);
        end else begin
          checkOutput("bresp", S_BRESP, bq[0]);
          if (M_BREADY) begin
            capBresp = S_BRESP;
            void'(bq.pop_front());
          end
        end
      end
    end
  end

  function automatic logic addrOutOfRange(input logic [ADDR_W-1:0] a);
    logic oor;
    oor = 1'b0;
`ifdef AXI_SLV_ADDR_CHK_EN
    oor = (a >= ADDR_W'(DEPTH));
`endif
    return oor;
  endfunction

  task automatic writeBurst(input logic [ADDR_W-1:0] addr, input int len,
                            input logic [DATA_W-1:0] base, input logic [3:0] strb,
                            input int lastBeat, input int bDelay, input int gap);
    logic              bad;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    int                waitCnt;
    bad = (lastBeat != len);
    for (int i = 0; i <= len; i++) begin
      a = addr + ADDR_W'(i);
      d = base + DATA_W'(i);
      if (addrOutOfRange(a)) begin
        bad = 1'b1;
      end else begin
        for (int b = 0; b < DATA_W/8; b++) begin
          if (strb[b]) model[a % DEPTH][b*8 +: 8] = d[b*8 +: 8];
        end
      end
    end
    bq.push_back(bad ? 2'b10 : 2'b00);

    M_AWVALID = 1'b1;
    M_AWADDR  = addr;
    M_AWLEN   = LEN_W'(len);
    waitCnt = 0;
    while (!S_AWREADY && waitCnt < 50) begin
      applyStimulus();
      waitCnt++;
    end
    if (waitCnt >= 50) checkOutput("awready_timeout", S_AWREADY, 1);
    applyStimulus();
    M_AWVALID = 1'b0;
    checkOutput("wready_after_aw", S_WREADY, 1);
    checkOutput("awready_busy", S_AWREADY, 0);

    for (int i = 0; i <= len; i++) begin
      M_WVALID = 1'b1;
      M_WDATA  = base + DATA_W'(i);
      M_WSTRB  = strb;
      M_WLAST  = (i == lastBeat);
      applyStimulus();
      M_WVALID = 1'b0;
      M_WLAST  = 1'b0;
      if (i < len) begin
        for (int g = 0; g < gap; g++) applyStimulus();
      end
    end
    checkOutput("bvalid_after_last", S_BVALID, 1);
    checkOutput("wready_drop", S_WREADY, 0);

    for (int k = 0; k < bDelay; k++) begin
      applyStimulus();
      checkOutput("bvalid_hold", S_BVALID, 1);
    end
    M_BREADY = 1'b1;
    applyStimulus();
    M_BREADY = 1'b0;
    checkOutput("bvalid_drop", S_BVALID, 0);
    checkOutput("bq_drained", bq.size(), 0);
  endtask

  task automatic arHandshake(input logic [ADDR_W-1:0] addr, input int len);
    int waitCnt;
    M_ARVALID = 1'b1;
    M_ARADDR  = addr;
    M_BLEN    = LEN_W'(len);
    waitCnt = 0;
    while (!S_ARREADY && waitCnt < 50) begin
      applyStimulus();
      waitCnt++;
    end
    if (waitCnt >= 50) checkOutput("arready_timeout", S_ARREADY, 1);
    applyStimulus();
    M_ARVALID = 1'b0;
    checkOutput("rvalid_after_ar", S_RVALID, 1);
    checkOutput("arready_busy", S_ARREADY, 0);
  endtask

  task automatic queueRead(input logic [ADDR_W-1:0] addr, input int len);
    rbeat_t            e;
    logic [ADDR_W-1:0] a;
    capData = {};
    capResp = {};
    capLast = {};
    for (int i = 0; i <= len; i++) begin
      a = addr + ADDR_W'(i);
      if (addrOutOfRange(a)) begin
        e.data = '0;
        e.resp = 2'b10;
      end else begin
        e.data = model[a % DEPTH];
        e.resp = 2'b00;
      end
      e.last = (i == len);
      rq.push_back(e);
    end
  endtask

  // mode 0: RREADY held high; mode 1: RREADY toggles, starting low.
  task automatic readBurst(input logic [ADDR_W-1:0] addr, input int len, input int mode);
    int cyc;
    queueRead(addr, len);
    arHandshake(addr, len);
    cyc = 0;
    while (rq.size() > 0 && cyc < 400) begin
      M_RREADY = (mode == 0) ? 1'b1 : ((cyc % 2) == 1);
      applyStimulus();
      cyc++;
    end
    M_RREADY = 1'b0;
    checkOutput("rq_drained", rq.size(), 0);
    checkOutput("rvalid_drop", S_RVALID, 0);
    checkOutput("arready_back", S_ARREADY, 1);
  endtask

  initial begin
    S_ARRESET_N = 1'b0;
    M_AWVALID = 0; M_AWADDR = '0; M_AWLEN = '0;
    M_WVALID = 0; M_WDATA = '0; M_WSTRB = '0; M_WLAST = 0;
    M_BREADY = 0;
    M_ARVALID = 0; M_ARADDR = '0; M_BLEN = '0;
    M_RREADY = 0;
    capBresp = 2'b11;
    for (int i = 0; i < DEPTH; i++) model[i] = '0;

    // Reset state: every output low.
    #2;
    checkOutput("rst_awready", S_AWREADY, 0);
    checkOutput("rst_arready", S_ARREADY, 0);
    checkOutput("rst_wready", S_WREADY, 0);
    checkOutput("rst_bvalid", S_BVALID, 0);
    checkOutput("rst_rvalid", S_RVALID, 0);
    checkOutput("rst_rdata", S_RDATA, 0);
    applyStimulus();
    applyStimulus();
    S_ARRESET_N = 1'b1;
    #1;
    checkOutput("awready_before_edge", S_AWREADY, 0);
    applyStimulus();
    checkOutput("awready_first_edge", S_AWREADY, 1);
    checkOutput("arready_first_edge", S_ARREADY, 1);

    // Single-beat write with one strobe lane, then read it back.
    $display("[TB] single-beat write/read");
    writeBurst(32'd0, 0, 32'h12345678, 4'b0001, 0, 0, 0);
    checkOutput("pin_single_bresp", capBresp, 2'b00);
    readBurst(32'd0, 0, 0);
    checkOutput("pin_single_rdata", capData[0], 32'h00000078);
    checkOutput("pin_single_rlast", capLast[0], 1);

    // Four-beat write burst and read-back.
    $display("[TB] 4-beat burst");
    writeBurst(32'd2, 3, 32'h000000A0, 4'b1111, 3, 0, 0);
    readBurst(32'd2, 3, 0);
    for (int i = 0; i < 4; i++) begin
      checkOutput("pin_burst_rdata", capData[i], 32'h000000A0 + i);
      checkOutput("pin_burst_rlast", capLast[i], (i == 3));
    end

    // WLAST too early: all beats stored, SLVERR; then with BREADY held off
    // and wait cycles between W beats.
    $display("[TB] WLAST mismatch");
    writeBurst(32'd8, 3, 32'h000000B0, 4'b1111, 1, 0, 0);
    checkOutput("pin_mismatch_bresp", capBresp, 2'b10);
    writeBurst(32'd12, 3, 32'h000000C0, 4'b1111, 1, 5, 2);
    checkOutput("pin_mismatch_hold_bresp", capBresp, 2'b10);

    // Full 16-beat read with RREADY toggling every cycle.
    $display("[TB] read backpressure");
    readBurst(32'd0, 15, 1);
    checkOutput("pin_bp_count", capData.size(), 16);
    checkOutput("pin_bp_word9", capData[9], 32'h000000B1);
    checkOutput("pin_bp_word15", capData[15], 32'h000000C3);

    // Burst crossing the top of the array.
    $display("[TB] out-of-range burst");
    writeBurst(32'd63, 1, 32'h000000D0, 4'b1111, 1, 0, 0);
    readBurst(32'd63, 1, 0);
    checkOutput("pin_oor_beat0", capData[0], 32'h000000D0);
    checkOutput("pin_oor_resp0", capResp[0], 2'b00);
`ifdef AXI_SLV_ADDR_CHK_EN
    checkOutput("pin_oor_bresp", capBresp, 2'b10);
    checkOutput("pin_oor_beat1", capData[1], 32'h00000000);
    checkOutput("pin_oor_resp1", capResp[1], 2'b10);
`else
    checkOutput("pin_oor_bresp", capBresp, 2'b00);
    checkOutput("pin_oor_beat1", capData[1], 32'h000000D1);
    checkOutput("pin_oor_resp1", capResp[1], 2'b00);
`endif

    // Reset while beat 2 of a 4-beat read is on the bus.
    $display("[TB] reset mid-burst");
    queueRead(32'd2, 3);
    arHandshake(32'd2, 3);
    M_RREADY = 1'b1;
    applyStimulus();
    applyStimulus();
    M_RREADY = 1'b0;
    checkOutput("mid_rvalid", S_RVALID, 1);
    checkOutput("mid_rq_left", rq.size(), 2);
    #2;
    S_ARRESET_N = 1'b0;
    #1;
    checkOutput("rst_mid_rvalid", S_RVALID, 0);
    checkOutput("rst_mid_rdata", S_RDATA, 0);
    checkOutput("rst_mid_arready", S_ARREADY, 0);
    rq = {};
    bq = {};
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    applyStimulus();
    applyStimulus();
    S_ARRESET_N = 1'b1;
    #1;
    checkOutput("rel_arready_low", S_ARREADY, 0);
    applyStimulus();
    checkOutput("rel_arready_high", S_ARREADY, 1);
    checkOutput("rel_awready_high", S_AWREADY, 1);
    readBurst(32'd2, 3, 0);
    for (int i = 0; i < 4; i++) begin
      checkOutput("pin_cleared_rdata", capData[i], 32'h00000000);
    end

    applyStimulus();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/axi_slave_burst_mem.md
# axi_slave_burst_mem

Parametrised AXI slave memory; successor to the single-beat write / burst-read slave FSM that pairs with `axi_master_fsm`. Adds incrementing write bursts, a B channel with response codes, RLAST/RRESP on reads, and configurable data width, depth and burst-length width. Read and write paths are independent FSMs sharing one byte-enabled register array.

## Interface

Parameters:
- DATA_W, 32: data bus width; multiple of 8.
- ADDR_W, 32: address width. Address is a word index, not a byte address.
- DEPTH, 64: number of DATA_W words.
- LEN_W, 4: burst-length field width. A burst is LEN+1 beats, 1..2^LEN_W.

Ports:
- S_ACLK, in, 1: single clock; all logic on rising edge.
- S_ARRESET_N, in, 1: asynchronous, active-low reset.
- M_AWVALID, in, 1 / M_AWADDR, in, ADDR_W / M_AWLEN, in, LEN_W / S_AWREADY, out, 1: write address channel.
- M_WVALID, in, 1 / M_WDATA, in, DATA_W / M_WSTRB, in, DATA_W/8 / M_WLAST, in, 1 / S_WREADY, out, 1: write data channel.
- S_BVALID, out, 1 / S_BRESP, out, 2 / M_BREADY, in, 1: write response channel.
- M_ARVALID, in, 1 / M_ARADDR, in, ADDR_W / M_BLEN, in, LEN_W / S_ARREADY, out, 1: read address channel.
- S_RVALID, out, 1 / S_RDATA, out, DATA_W / S_RRESP, out, 2 / S_RLAST, out, 1 / M_RREADY, in, 1: read data channel.

## Operation

- **Reset.** All outputs are 0; both FSMs enter IDLE; the memory array is cleared to 0.
- **Ready flags.** S_AWREADY and S_ARREADY are registered. They rise at the first edge after reset release.
- **Write FSM: W_IDLE → W_DATA → W_RESP → W_IDLE.**
  - W_IDLE: S_AWREADY=1. On the AW handshake, latch address and length, clear the beat counter and error flag, then go to W_DATA.
  - W_DATA: S_WREADY=1. On each W handshake, write the bytes whose M_WSTRB bit is set, increment the address, and increment the count.
  - On the beat where count==LEN, go to W_RESP.
  - If M_WLAST does not equal (count==LEN) on any beat, set the error flag. The data is still written.
  - W_RESP: S_BVALID=1, S_BRESP = SLVERR (2'b10) if the error flag is set, else OKAY (2'b00). Hold until M_BREADY, then return to W_IDLE.
- **Read FSM: R_IDLE → R_DATA → R_IDLE.**
  - R_IDLE: S_ARREADY=1. On the AR handshake, latch address and length, and register mem[addr] into S_RDATA.
  - R_DATA: S_RVALID=1. S_RLAST=1 on beat count==LEN.
  - On each R handshake, advance the address and load the next word. After the last beat, drop S_RVALID and return to R_IDLE.
- **Address arithmetic.** Incrementing, with a width of ADDR_W. The array index is addr[$clog2(DEPTH)-1:0].
- **Concurrency.** Read and write run concurrently. When a read and a write hit the same word on the same edge, the read returns the old data.

## Timing

- AW handshake at edge N → S_WREADY=1 from N+1.
- Last W beat at edge M → S_BVALID=1 from M+1.
- AR handshake at edge N → S_RVALID with beat 0 from N+1.
- Back-to-back beats run with no bubble while M_RREADY=1.
- Stalls:
  - M_RREADY=0 holds S_RDATA, S_RLAST and S_RRESP stable.
  - M_WVALID=0 inserts wait cycles with no write.
- VALID outputs never depend combinationally on the master's READY.
- After a BREADY or last-beat handshake, the next address can be accepted at the earliest one cycle later, because READY re-asserts from IDLE.
- Reset asserted mid-burst forces IDLE immediately. It clears all outputs and the memory, and the partial burst is discarded.

## Configuration

- **AXI_SLV_ADDR_CHK_EN defined:**
  - Any beat whose full ADDR_W address is ≥ DEPTH is out of range.
  - Out-of-range writes are suppressed, and BRESP=SLVERR.
  - Out-of-range reads return RDATA=0 with RRESP=SLVERR for that beat only.
- **AXI_SLV_ADDR_CHK_EN undefined:**
  - The address wraps modulo DEPTH.
  - RRESP is always OKAY, and BRESP reflects only the WLAST mismatch.

## Structure

- **Package `axi_slv_pkg`:**
  - Response constants RESP_OKAY=2'b00 and RESP_SLVERR=2'b10.
  - Write-FSM and read-FSM state enums.
- **Sub-module `axi_slv_mem_array`:**
  - DEPTH×DATA_W array with asynchronous clear.
  - One byte-enabled write port and one read port; the read port is combinational, and the caller registers it.

## Test plan

- **Single-beat write then read.** AW addr 0, len 0, WDATA 0x12345678, STRB 0001; BREADY=1 → BRESP=OKAY. AR addr 0, len 0 → RDATA=0x00000078, RLAST=1.
- **Write burst then read-back.** AW addr 2, len 3, data 0xA0..0xA3, STRB 1111, WLAST on beat 3 → words 2..5 hold 0xA0..0xA3. AR addr 2, BLEN 3 → four beats, RLAST only on the 4th.
- **Read backpressure.** BLEN 15 from addr 0 with M_RREADY toggling every cycle → 16 beats delivered in order, data held stable while stalled.
- **WLAST mismatch.** AW len 3 with WLAST on beat 1 → all 4 beats written, BRESP=SLVERR. Repeat with BREADY held low 5 cycles → BVALID and BRESP held for those cycles.
- **Out-of-range with AXI_SLV_ADDR_CHK_EN.** AW addr 63, len 1, DEPTH 64 → word 63 written, word 0 untouched, BRESP=SLVERR. AR addr 63, BLEN 1 → beat 0 OKAY, beat 1 RDATA=0 with SLVERR. Without the macro, beat 1 wraps to word 0 and is OKAY.
- **Reset mid-burst.** S_ARRESET_N low during beat 2 of a 4-beat read → S_RVALID=0 immediately. After release, S_ARREADY=1 one edge later and the memory reads back 0.
